// File: rtl/async_fifo_gray_pkg.sv
// Shared definitions for the dual-clock Gray-pointer FIFO.
// Holds the pointer Gray/binary conversions, the pointer width helper and
// the smallest legal parameter values checked at elaboration by the top.
package async_fifo_gray_pkg;

    // Full detection inverts the two pointer MSBs, so at least two address bits.
    localparam int MIN_ADDR_WIDTH  = 2;
    localparam int MIN_SYNC_STAGES = 2;

    // Conversions work on a wide vector; callers zero-extend and truncate.
    localparam int PTR_MAX_W = 32;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync_vec.sv
// Multi-flop synchroniser for an N-bit vector with asynchronous active-low
// reset. Used for Gray pointer crossings and, with WIDTH=1 and d_i tied high,
// as a reset synchroniser (async assert, synchronous deassert).
// Ports: clk_i destination clock, rst_n_i async reset, d_i input vector,
//        q_o synchronised vector (STAGES destination edges of latency).
module fifo_sync_vec #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointers crossing through synchronisers.
// Write side (wclk): wr, data_in, wr_full, wr_level, high_th/wr_high_th,
//   sticky overflow wr_ov cleared by ov_clr.
// Read side (rclk): rd, data_out, rd_valid, rd_empty, rd_level,
//   low_th/rd_low_th, sticky underflow rd_ud cleared by ud_clr.
// rst_n is asynchronous active-low; each domain deasserts it through its own
// two-flop synchroniser.
module async_fifo_gray
    import async_fifo_gray_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  wclk,
    input  logic                  rclk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  wr_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    input  logic [ADDR_WIDTH:0]   high_th,
    output logic                  wr_high_th,
    output logic                  wr_ov,
    input  logic                  ov_clr,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    input  logic [ADDR_WIDTH:0]   low_th,
    output logic                  rd_low_th,
    output logic                  rd_ud,
    input  logic                  ud_clr
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (SYNC_STAGES < MIN_SYNC_STAGES || ADDR_WIDTH < MIN_ADDR_WIDTH) begin : g_param_err
        $error("async_fifo_gray: SYNC_STAGES or ADDR_WIDTH below minimum");
    end

    logic                  wrst_n, rrst_n;
    logic [PTR_W-1:0]      rgray_w, wgray_r;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             winc;
    logic [PTR_W-1:0] wbin_q, wbin_d, wgray_q, wgray_d, wlevel_q, wlevel_d;
    logic             wfull_q, wfull_d, wov_q, wov_d;

    logic                  rinc;
    logic [PTR_W-1:0]      rbin_q, rbin_d, rgray_q, rgray_d, rlevel_q, rlevel_d;
    logic                  rempty_q, rempty_d, rud_q, rud_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    fifo_sync_vec #(.WIDTH(1), .STAGES(2)) u_wrst_sync (
        .clk_i(wclk), .rst_n_i(rst_n), .d_i(1'b1), .q_o(wrst_n)
    );
    fifo_sync_vec #(.WIDTH(1), .STAGES(2)) u_rrst_sync (
        .clk_i(rclk), .rst_n_i(rst_n), .d_i(1'b1), .q_o(rrst_n)
    );

    // Gray registers feed the synchronisers directly.
    fifo_sync_vec #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rgray_sync (
        .clk_i(wclk), .rst_n_i(wrst_n), .d_i(rgray_q), .q_o(rgray_w)
    );
    fifo_sync_vec #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wgray_sync (
        .clk_i(rclk), .rst_n_i(rrst_n), .d_i(wgray_q), .q_o(wgray_r)
    );

    // ---------------- write domain ----------------
    always_comb begin
        winc     = wr & ~wfull_q;
        wbin_d   = wbin_q + PTR_W'(winc);
        wgray_d  = PTR_W'(bin2gray(PTR_MAX_W'(wbin_d)));
        // Full when the writer is exactly one lap ahead: top two Gray bits differ.
        wfull_d  = (wgray_d == {~rgray_w[PTR_W-1 -: 2], rgray_w[PTR_W-3:0]});
        wlevel_d = wbin_d - PTR_W'(gray2bin(PTR_MAX_W'(rgray_w)));
        wov_d    = ov_clr ? 1'b0 : (wov_q | (wr & wfull_q));
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wfull_q  <= 1'b0;
            wlevel_q <= '0;
            wov_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wfull_q  <= wfull_d;
            wlevel_q <= wlevel_d;
            wov_q    <= wov_d;
        end
    end

    always_ff @(posedge wclk) begin
        if (winc) begin
            mem[wbin_q[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    // ---------------- read domain ----------------
    always_comb begin
        rinc     = rd & ~rempty_q;
        rbin_d   = rbin_q + PTR_W'(rinc);
        rgray_d  = PTR_W'(bin2gray(PTR_MAX_W'(rbin_d)));
        rempty_d = (rgray_d == wgray_r);
        rlevel_d = PTR_W'(gray2bin(PTR_MAX_W'(wgray_r))) - rbin_d;
        rud_d    = ud_clr ? 1'b0 : (rud_q | (rd & rempty_q));
        rvalid_d = rinc;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            rempty_q <= 1'b1;
            rlevel_q <= '0;
            rud_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            rempty_q <= rempty_d;
            rlevel_q <= rlevel_d;
            rud_q    <= rud_d;
            rvalid_q <= rvalid_d;
            if (rinc) begin
                rdata_q <= mem[rbin_q[ADDR_WIDTH-1:0]];
            end
        end
    end

    assign wr_full    = wfull_q;
    assign wr_level   = wlevel_q;
    assign wr_high_th = (wlevel_q >= high_th);
    assign wr_ov      = wov_q;
    assign data_out   = rdata_q;
    assign rd_valid   = rvalid_q;
    assign rd_empty   = rempty_q;
    assign rd_level   = rlevel_q;
    assign rd_low_th  = (rlevel_q < low_th);
    assign rd_ud      = rud_q;

endmodule

// File: doc/async_fifo_gray.md
Name: async_fifo_gray

Overview:
- Dual-clock FIFO: writer on wclk, reader on rclk, with no phase or frequency relationship assumed between them.
- Pointers cross domains in Gray code through multi-stage synchronisers.
- Each side gets its own conservative full/empty flags, fill level, threshold flag and sticky overflow/underflow flag.
- Replaces single-clock FIFO instances wherever producer and consumer clocks differ.

Parameters:
- DATA_WIDTH, 8, data word width.
- ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH (min 2).
- SYNC_STAGES, 2, flops per pointer synchroniser (min 2).

Ports:
- wclk  in  1  write-domain clock.
- rclk  in  1  read-domain clock.
- rst_n  in  1  reset, asynchronous, active-low; clock wclk (read side uses its own rclk-synchronised copy).
- wr  in  1  write request (wclk).
- data_in  in  DATA_WIDTH  write data.
- wr_full  out  1  FIFO full, wclk domain.
- wr_level  out  ADDR_WIDTH+1  write-side occupancy.
- high_th  in  ADDR_WIDTH+1  high threshold, quasi-static.
- wr_high_th  out  1  wr_level >= high_th.
- wr_ov  out  1  sticky overflow flag.
- ov_clr  in  1  clears wr_ov (wclk).
- rd  in  1  read request (rclk).
- data_out  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  data_out updated this cycle.
- rd_empty  out  1  FIFO empty, rclk domain.
- rd_level  out  ADDR_WIDTH+1  read-side occupancy.
- low_th  in  ADDR_WIDTH+1  low threshold, quasi-static.
- rd_low_th  out  1  rd_level < low_th.
- rd_ud  out  1  sticky underflow flag.
- ud_clr  in  1  clears rd_ud (rclk).

Behaviour:
- Reset:
  - Assertion is asynchronous to both domains.
  - Deassertion passes through a 2-flop synchroniser per domain.
  - Reset values: all pointers 0, wr_full 0, rd_empty 1, levels 0, wr_ov 0, rd_ud 0, rd_valid 0, data_out 0, wr_high_th = (0 >= high_th), rd_low_th = (0 < low_th).
  - Reset mid-operation discards all contents.
- Pointers:
  - Binary and Gray pointers are ADDR_WIDTH+1 bits; Gray = bin ^ (bin >> 1).
  - Gray pointers are registered before crossing; no combinational logic sits between the Gray register and the synchroniser.
- Write (wclk):
  - A write is accepted when wr & ~wr_full.
  - data_in is stored at wptr[ADDR_WIDTH-1:0] and wptr increments.
  - wr & wr_full drops the data and sets wr_ov on the next edge.
- wr_full is registered and equals (next wgray == synced rgray with its two MSBs inverted).
- Read (rclk):
  - A read is accepted when rd & ~rd_empty.
  - data_out <= mem[rptr] on the same edge, rptr increments, and rd_valid = 1 for one cycle.
  - rd & rd_empty sets rd_ud; data_out holds and rd_valid = 0.
- rd_empty is registered and equals (next rgray == synced wgray).
- Latency: a write becomes visible to the reader (rd_empty falls) after SYNC_STAGES+1 rclk edges, give or take one. A read frees space on the writer side after SYNC_STAGES+1 wclk edges.
- Levels:
  - wr_level = wptr − bin(synced rgray), mod 2**(ADDR_WIDTH+1).
  - rd_level = bin(synced wgray) − rptr.
  - Both are registered and pessimistic (over-estimate on write side, under-estimate on read side), never exceeding depth.
- Sticky flags: clear has priority over set when both occur in the same cycle; ov_clr & wr & wr_full leaves wr_ov = 0.
- Wrap-around: pointer MSB toggles every depth accesses; the full/empty distinction relies solely on the MSB.
- Simultaneous read and write in the same cycle are always safe and occur independently in each domain.
- Memory has no reset; it is inferred as a simple dual-port RAM (write on wclk, read on rclk).

Decomposition:
- Shared package holds:
  - bin2gray and gray2bin functions.
  - Pointer-width constant ADDR_WIDTH+1.
  - Minimum legal values for SYNC_STAGES and ADDR_WIDTH (elaboration check).
- One sub-module, fifo_sync_vec: a SYNC_STAGES-deep, N-bit vector synchroniser with async reset. It is instantiated twice (wgray to rclk, rgray to wclk) and also serves as the reset synchroniser with N=1.

Test Plan:
- Reset with wclk 100 MHz / rclk 37 MHz → rd_empty=1, wr_full=0, levels 0, flags 0.
- Write 16 words 0x00..0x0F with no reads → wr_full=1 after the 16th write; wr_level=16. A 17th write of 0xAA → wr_ov=1 and data is dropped. Reading all 16 returns 0x00..0x0F in order, then rd_empty=1.
- Read on empty with rd=1 → rd_ud=1, rd_valid=0, data_out unchanged. ud_clr and rd in the same cycle → rd_ud=0.
- Single write of 0x5A into an empty FIFO → rd_empty falls within 3–4 rclk edges; read gives data_out=0x5A with rd_valid=1 for exactly one cycle.
- Continuous random wr/rd for 10k words at ratios 3:1 and 1:3 → scoreboard matches; no writes accepted while wr_full; no reads accepted while rd_empty.
- high_th=12 with 12 words written → wr_high_th=1. low_th=4: rd_low_th=1 until rd_level reaches 4. Asserting rst_n low mid-stream → both sides return to reset values within 1 edge.
